// File: rtl/delay_measure.sv
// Recovers the lag between a reference stream and its delayed copy by capturing
// a SIGLEN-word signature from the reference and searching for it in the delayed stream.
module delay_measure #(
  parameter int LGDLY  = 4,
  parameter int DW     = 12,
  parameter int SIGLEN = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_ce,
  input  logic             i_start,
  input  logic [DW-1:0]    i_ref,
  input  logic [DW-1:0]    i_dly,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [LGDLY-1:0] o_delay
);

  localparam int KW = LGDLY + 2;
  localparam int HN = (SIGLEN > 1) ? SIGLEN - 1 : 1;
  localparam logic [KW-1:0] K_CAP_END = KW'(SIGLEN - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(SIGLEN - 1 + (1 << LGDLY) - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SEARCH  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [SIGLEN*DW-1:0] sig_q, sig_d;
  logic [HN*DW-1:0]     hist_q, hist_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic [LGDLY-1:0]     delay_q, delay_d;

  logic [SIGLEN*DW-1:0] win_s;
  logic                 sample_s, eq_s, match_s, last_s;

  // Word 0 of the window is the current i_dly; word SIGLEN-1 is the oldest.
  generate
    if (SIGLEN > 1) begin : g_win
      assign win_s = {hist_q, i_dly};
    end else begin : g_win1
      assign win_s = i_dly;
    end
  endgenerate

  assign sample_s = i_ce && !i_start &&
                    ((state_q == S_CAPTURE) || (state_q == S_SEARCH));

  // Signature capture with bypass so the word stored this sample is compared immediately.
  always_comb begin
    sig_d = sig_q;
    if (sample_s && (state_q == S_CAPTURE)) begin
      for (int i = 0; i < SIGLEN; i++) begin
        if (k_q == KW'(i)) begin
          sig_d[i*DW +: DW] = i_ref;
        end else begin
          sig_d[i*DW +: DW] = sig_q[i*DW +: DW];
        end
      end
    end else begin
      sig_d = sig_q;
    end
  end

  // Window shift and signature comparison.
  always_comb begin
    hist_d = hist_q;
    eq_s   = 1'b1;
    if (sample_s) begin
      hist_d = win_s[HN*DW-1:0];
    end else begin
      hist_d = hist_q;
    end
    for (int i = 0; i < SIGLEN; i++) begin
      if (win_s[(SIGLEN-1-i)*DW +: DW] != sig_d[i*DW +: DW]) begin
        eq_s = 1'b0;
      end else begin
        eq_s = eq_s;
      end
    end
  end

  assign match_s = sample_s && eq_s && (k_q >= K_CAP_END);
  assign last_s  = sample_s && (k_q == K_LAST);

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      sig_q     <= '0;
      hist_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      delay_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      sig_q     <= sig_d;
      hist_q    <= hist_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      delay_q   <= delay_d;
    end
  end

  // Next-state logic; a start request overrides everything, including a same-cycle match.
  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = S_CAPTURE;
    end else begin
      case (state_q)
        S_CAPTURE, S_SEARCH: begin
          if (match_s || last_s) begin
            state_d = S_DONE;
          end else if (sample_s && (state_q == S_CAPTURE) && (k_q == K_CAP_END)) begin
            state_d = S_SEARCH;
          end else begin
            state_d = state_q;
          end
        end
        S_IDLE, S_DONE: state_d = state_q;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Output and counter next values.
  always_comb begin
    k_d       = k_q;
    busy_d    = busy_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    delay_d   = delay_q;
    if (i_start) begin
      k_d       = '0;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end else if (sample_s) begin
      k_d = k_q + KW'(1);
      if (match_s) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        delay_d = k_q[LGDLY-1:0] - LGDLY'(SIGLEN - 1);
      end else if (last_s) begin
        timeout_d = 1'b1;
        busy_d    = 1'b0;
      end else begin
        busy_d = busy_q;
      end
    end else begin
      k_d = k_q;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_timeout = timeout_q;
  assign o_delay   = delay_q;

endmodule
